fifo_uart_tx: RTL

UART transmitter that drains the team's show-ahead FIFO and serializes each word onto a single asynchronous serial line. It sits directly downstream of the FIFO: it drives the FIFO read enable, consumes the read data, and watches the FIFO empty flag. It also honours a clear-to-send input from the far end.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 27 ++
 rtl/fifo_uart_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and parameter checks for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Elaboration-time legality of a transmitter configuration.
  function automatic bit params_ok(int unsigned data_bits, int unsigned clks_per_bit,
                                   int unsigned parity, int unsigned stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) && (clks_per_bit >= 2) &&
           ((parity == PAR_NONE) || (parity == PAR_EVEN) || (parity == PAR_ODD)) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle of a period.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  output logic last_cycle_c
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q;

  assign last_cycle_c = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear || last_cycle_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO; pops a word, then shifts out
// start, data (LSB first), optional parity and stop bits on tx_o.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 cts_ni,
  input  logic                 empty_i,
  input  logic [DATA_BITS-1:0] rd_data_i,
  output logic                 rd_en_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int unsigned    IW         = $clog2(DATA_BITS);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(DATA_BITS - 1);
  localparam bit             HAS_PARITY = (PARITY != PAR_NONE);
  localparam bit             ODD_PARITY = (PARITY == PAR_ODD);

  if (!params_ok(DATA_BITS, CLKS_PER_BIT, PARITY, STOP_BITS)) begin : g_bad_params
    $error("fifo_uart_tx: illegal parameter combination");
  end

  uart_state_e          state_q, state_d;
  logic                 tick;
  logic                 clear;
  logic                 pop_ok;
  logic                 stop_last;
  logic                 frame_end;
  logic [DATA_BITS-1:0] shreg_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear       (clear),
    .last_cycle_c(tick)
  );

  // Reset gates the pop so nothing leaves the FIFO while the block is held in reset.
  assign pop_ok    = rst_ni & enable_i & ~cts_ni & ~empty_i;
  assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
  assign frame_end = (state_q == ST_STOP) & tick & stop_last;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pop_ok) state_d = ST_START;
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA:   if (tick && (bit_idx_q == LAST_IDX)) state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (frame_end) state_d = pop_ok ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pop strobe and bit-timer restart on every state entry.
  always_comb begin
    rd_en_o = 1'b0;
    clear   = 1'b0;
    if (pop_ok && ((state_q == ST_IDLE) || frame_end)) begin
      rd_en_o = 1'b1;
    end
    if ((state_q == ST_IDLE) || (state_d != state_q)) begin
      clear = 1'b1;
    end
  end

  // Shift datapath; tx_q always holds the level of the bit currently on the line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else if (rd_en_o) begin
      shreg_q    <= rd_data_i;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= (^rd_data_i) ^ ODD_PARITY;
      tx_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else if (tick) begin
      unique case (state_q)
        ST_START: tx_q <= shreg_q[0];
        ST_DATA: begin
          if (bit_idx_q == LAST_IDX) begin
            tx_q <= HAS_PARITY ? par_q : 1'b1;
          end else begin
            tx_q      <= shreg_q[1];
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + IW'(1);
          end
        end
        ST_PARITY: tx_q <= 1'b1;
        ST_STOP: begin
          if (stop_last) begin
            busy_q <= 1'b0;
          end else begin
            stop_idx_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule
